// File: rtl/carry_skip_sequencer.sv
// Multi-cycle adder front end: slices two WIDTH-bit operands into BLOCK-bit chunks,
// feeds them one per cycle to an external carry-skip block and reassembles the sum.
module carry_skip_sequencer #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [BLOCK-1:0] blk_a,
    output logic [BLOCK-1:0] blk_b,
    output logic             blk_cin,
    input  logic [BLOCK-1:0] blk_sum,
    input  logic             blk_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NB    = WIDTH / BLOCK;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [BLOCK-1:0] acc_reg [NB];
    logic [WIDTH-1:0] out_sum_reg;
    logic             out_cout_reg;

    logic [BLOCK-1:0] a_chunk  [NB];
    logic [BLOCK-1:0] b_chunk  [NB];
    logic [BLOCK-1:0] acc_next [NB];
    logic [WIDTH-1:0] sum_flat;
    logic             run_step;
    logic             last_step;

    assign run_step  = (state_reg == RUN);
    assign last_step = run_step && (idx_reg == LAST_IDX);

    // Per-chunk views; sum_flat already contains the chunk being written this cycle,
    // so the final edge can publish the complete result without an extra cycle.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_chunk
            assign a_chunk[gi]  = a_reg[gi*BLOCK +: BLOCK];
            assign b_chunk[gi]  = b_reg[gi*BLOCK +: BLOCK];
            assign acc_next[gi] = (run_step && (idx_reg == IDX_W'(gi))) ? blk_sum : acc_reg[gi];
            assign sum_flat[gi*BLOCK +: BLOCK] = acc_next[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        blk_a      = '0;
        blk_b      = '0;
        blk_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                blk_a   = a_chunk[idx_reg];
                blk_b   = b_chunk[idx_reg];
                blk_cin = carry_reg;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '{default: '0};
            out_sum_reg  <= '0;
            out_cout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= blk_cout;
                    if (last_step) begin
                        // Wrap instead of incrementing so idx never leaves 0..NB-1.
                        idx_reg      <= '0;
                        out_sum_reg  <= sum_flat;
                        out_cout_reg <= blk_cout;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = out_sum_reg;
    assign out_cout = out_cout_reg;

endmodule

// File: tb/tb_carry_skip_sequencer.sv
// Directed and randomized checks of carry_skip_sequencer (WIDTH=16, BLOCK=4) with a
// behavioural chunk adder standing in for the downstream carry-skip block.
module tb_carry_skip_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [3:0]  blk_a;
    logic [3:0]  blk_b;
    logic        blk_cin;
    logic [3:0]  blk_sum;
    logic        blk_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign {blk_cout, blk_sum} = {1'b0, blk_a} + {1'b0, blk_b} + {4'b0000, blk_cin};

    carry_skip_sequencer #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .blk_a     (blk_a),
        .blk_b     (blk_b),
        .blk_cin   (blk_cin),
        .blk_sum   (blk_sum),
        .blk_cout  (blk_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int stall, input bit noise);
        logic [16:0] full;
        logic [16:0] part;
        logic [15:0] m;
        logic [15:0] sh;
        int edges;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        check("idle_ready", in_ready, 1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (edges < 4) begin
                m    = 16'((17'd1 << (4 * edges)) - 17'd1);
                part = {1'b0, a & m} + {1'b0, b & m} + {16'd0, cin};
                sh   = a >> (4 * edges);
                check("blk_a", blk_a, sh[3:0]);
                check("blk_cin", blk_cin, part[4 * edges]);
            end
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = 16'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        in_valid = 1'b0;
        check("latency", edges, 4);
        check("sum", out_sum, full[15:0]);
        check("cout", out_cout, full[16]);
        repeat (stall) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, full[15:0]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("retain_sum", out_sum, full[15:0]);
        check("retain_cout", out_cout, full[16]);
    endtask

    initial begin
        logic [15:0] sa [3];
        logic [15:0] sb [3];
        logic        sc [3];
        logic [15:0] es [3];
        logic        ec [3];
        int k, got, t, last_t, edges;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_blk_a", blk_a, 0);
        check("rst_blk_cin", blk_cin, 0);
        rst_n = 1'b1;

        // Full ripple: carry propagates through every chunk
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, 1'b0);

        // Backpressure with a pending new request held on the input
        in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("bp_latency", edges, 4);
        check("bp_sum", out_sum, 16'h5556);
        check("bp_cout", out_cout, 0);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_hold_sum", out_sum, 16'h5556);
            check("bp_hold_cout", out_cout, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_blk_a", blk_a, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);
        check("bp_retain_sum", out_sum, 16'h5556);
        @(negedge clk);
        check("bp_accept_new", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("bp2_latency", edges, 4);
        check("bp2_sum", out_sum, 16'h1000);
        check("bp2_cout", out_cout, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Leave a nonzero result behind so the reset clearing is visible
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);

        // Reset while idx==2
        in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_blk_a_idx2", blk_a, 0);
        check("mid_in_ready", in_ready, 0);
        rst_n = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("mr_in_ready", in_ready, 1);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_sum", out_sum, 0);
        check("mr_out_cout", out_cout, 0);
        check("mr_blk_a", blk_a, 0);
        check("mr_blk_b", blk_b, 0);
        check("mr_blk_cin", blk_cin, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("mr_no_capture", in_ready, 1);
        check("mr_no_valid", out_valid, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1, 1'b0);

        // Streaming with in_valid and out_ready held high
        sa[0] = 16'h00FF; sb[0] = 16'h0001; sc[0] = 1'b0; es[0] = 16'h0100; ec[0] = 1'b0;
        sa[1] = 16'h7FFF; sb[1] = 16'h7FFF; sc[1] = 1'b0; es[1] = 16'hFFFE; ec[1] = 1'b0;
        sa[2] = 16'h0000; sb[2] = 16'h0000; sc[2] = 1'b1; es[2] = 16'h0001; ec[2] = 1'b0;
        out_ready = 1'b1;
        in_a = sa[0]; in_b = sb[0]; in_cin = sc[0]; in_valid = 1'b1;
        k = 1; got = 0; t = 0; last_t = 0;
        while (got < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                check("stream_sum", out_sum, es[got]);
                check("stream_cout", out_cout, ec[got]);
                if (got > 0) check("stream_period", t - last_t, 6);
                last_t = t;
                got++;
            end
            if (in_ready) begin
                if (k < 3) begin
                    in_a = sa[k]; in_b = sb[k]; in_cin = sc[k];
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("stream_count", got, 3);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/carry_skip_sequencer.md
CARRY_SKIP_SEQUENCER -- requirements
Module: carry_skip_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: total operand width in bits.
REQ-002 SHALL have parameter BLOCK, default 4: chunk width; WIDTH SHALL be an integer multiple of BLOCK, and NB = WIDTH/BLOCK.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
  clk  in  1  rising-edge clock.
  rst_n  in  1  synchronous active-low reset.
  in_valid  in  1  operand request.
  in_ready  out  1  sequencer can accept operands.
  in_a, in_b  in  WIDTH  addends.
  in_cin  in  1  carry-in.
  blk_a, blk_b  out  BLOCK  current chunk, driven to a downstream combinational carry-skip block.
  blk_cin  out  1  carry into current chunk.
  blk_sum  in  BLOCK  chunk sum returned by that block.
  blk_cout  in  1  chunk carry-out returned by that block.
  out_valid  out  1  result available.
  out_ready  in  1  consumer accepts result.
  out_sum  out  WIDTH  full sum.
  out_cout  out  1  final carry-out.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-006 IDLE: on a clock edge with in_valid=1, SHALL capture in_a, in_b, in_cin into internal registers, clear the chunk index idx to 0, set the carry register to in_cin, and go to RUN.
REQ-007 RUN: blk_a/blk_b SHALL be bits [idx*BLOCK +: BLOCK] of the captured operands and blk_cin SHALL be the carry register, all driven combinationally from registers.
REQ-008 RUN, each edge:
  - SHALL write blk_sum into sum slice idx.
  - SHALL load the carry register with blk_cout.
  - SHALL increment idx.
REQ-009 RUN: on the edge where idx==NB-1, SHALL go to DONE, load out_cout with blk_cout, and complete out_sum.
REQ-010 Latency: SHALL assert out_valid exactly NB edges after the accepting edge (4 for defaults).
REQ-011 DONE: SHALL hold out_valid, out_sum and out_cout stable until an edge with out_ready=1, then go to IDLE.
REQ-012 Throughput: SHALL complete back-to-back operations with a period of NB+2 cycles when in_valid and out_ready are held high.
REQ-013 In IDLE and DONE, blk_a, blk_b and blk_cin SHALL be 0.
REQ-014 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-015 out_sum and out_cout SHALL retain the last result after leaving DONE until the next completion.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of the top chunk reported only on out_cout.
REQ-017 idx SHALL be ceil(log2(NB)) bits wide (minimum 1) and SHALL never exceed NB-1.
REQ-018 When NB==1, SHALL spend one RUN cycle and then go to DONE.

Reset
REQ-019 With rst_n=0 at an edge, SHALL go to IDLE and clear to 0: idx, carry, operand registers, out_sum, out_cout, out_valid.
REQ-020 After reset, in_ready SHALL be 1.
REQ-021 Reset SHALL override any in-flight operation in RUN or DONE; the partial result is discarded and out_valid is 0 on the next cycle.
REQ-022 in_valid asserted during reset SHALL NOT be captured.

Verification (WIDTH=16, BLOCK=4)
REQ-023 Full ripple: a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1; out_valid rises 4 edges after acceptance; blk_cin=1 in chunks 1-3.
REQ-024 Carry-in: a=0x1234, b=0x4321, cin=1 -> out_sum=0x5556, out_cout=0.
REQ-025 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cout stable; in_ready=0 throughout; a new in_valid is not accepted until after the out_ready handshake.
REQ-026 Reset mid-RUN: rst_n=0 at idx=2 of 0x8000+0x8000 -> next cycle IDLE, out_valid=0, out_sum=0, out_cout=0, blk_* = 0.
REQ-027 Streaming: 3 operations (0x00FF+0x0001, 0x7FFF+0x7FFF, 0x0000+0x0000 cin=1) with in_valid and out_ready held high -> results 0x0100/0, 0xFFFE/0, 0x0001/0 at 6-cycle spacing.
REQ-028 Random: 1000 random operand sets with random out_ready stalls -> every result equals a+b+cin, modulo 2^16 with carry on out_cout.
